// File: rtl/vga_mon_pkg.sv
// Shared definitions for the VGA receive-side monitor.
// Holds the 640x480 timing constants, the lock FSM state type and the
// counter widths used by vga_sync_monitor.
package vga_mon_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int X_W   = 10;
  localparam int CNT_W = 19;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Strobe-gated edge detector for one sync line.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_stb        : sample enable; edges are only reported while high
//   i_d          : sync input
//   o_fall/o_rise: combinational edge flags for the current strobe
// The history register resets to 1 so an idle-high sync line never
// produces a spurious edge after reset.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,
  input  logic i_d,
  output logic o_fall,
  output logic o_rise
);

  logic q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q <= 1'b1;
    end else if (i_stb) begin
      q <= i_d;
    end
  end

  assign o_fall = i_stb & q & ~i_d;
  assign o_rise = i_stb & ~q & i_d;

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA monitor: rebuilds pixel coordinates from HS/VS,
// checks sync timing, tracks lock and collects per-frame statistics.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_pix_stb        : pixel strobe, all inputs sampled only when high
//   i_hs, i_vs       : active-low syncs
//   i_r, i_g, i_b    : pixel colour (only green is measured)
//   o_x, o_y         : coordinates inside the active area, else 0
//   o_active         : sample lies in the active area
//   o_locked         : timing locked
//   o_frame_done     : one-cycle pulse per frame boundary
//   o_frame_cnt      : frames completed while locked (wraps)
//   o_err_cnt        : timing errors while locked (saturates)
//   o_green_px       : green pixels in the last complete frame
module vga_sync_monitor
  import vga_mon_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_stb,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic [1:0]       i_r,
  input  logic [2:0]       i_g,
  input  logic [2:0]       i_b,
  output logic [X_W-1:0]   o_x,
  output logic [X_W-1:0]   o_y,
  output logic             o_active,
  output logic             o_locked,
  output logic             o_frame_done,
  output logic [15:0]      o_frame_cnt,
  output logic [7:0]       o_err_cnt,
  output logic [CNT_W-1:0] o_green_px
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] V_LAST   = X_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0] H_SYNC_W = X_W'(H_SYNC);
  localparam logic [X_W-1:0] V_SYNC_W = X_W'(V_SYNC);
  localparam logic [X_W-1:0] H_FIRST  = X_W'(H_SYNC + H_BP);
  localparam logic [X_W-1:0] H_END    = X_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [X_W-1:0] V_FIRST  = X_W'(V_SYNC + V_BP);
  localparam logic [X_W-1:0] V_END    = X_W'(V_SYNC + V_BP + V_ACTIVE - 1);

  function automatic logic [X_W-1:0] sat_inc_pos(input logic [X_W-1:0] v);
    return (v == {X_W{1'b1}}) ? v : v + X_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             hs_fall, hs_rise, vs_fall, vs_rise;
  logic [X_W-1:0]   h_cnt, v_cnt, h_next, v_next, x_next, y_next;
  logic             vs_pend, vs_pend_next, boundary;
  logic             h_err, v_err, err_now;
  logic             act_next, green_hit;
  logic [CNT_W-1:0] green_cnt;
  mon_state_t       state, state_next;
  logic             err_seen, err_seen_next, frame_inc, err_inc;
  logic             rgb_unused;

  // Red and blue pass through the display path but are not measured.
  assign rgb_unused = ^{i_r, i_b};

  sync_edge_det u_hs_edge (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_stb (i_pix_stb),
    .i_d   (i_hs),
    .o_fall(hs_fall),
    .o_rise(hs_rise)
  );

  sync_edge_det u_vs_edge (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_stb (i_pix_stb),
    .i_d   (i_vs),
    .o_fall(vs_fall),
    .o_rise(vs_rise)
  );

  // Counts describe the current sample: h_next/v_next are the values this
  // strobe will register, and all checks and coordinates use them.
  always_comb begin
    h_next       = hs_fall ? '0 : sat_inc_pos(h_cnt);
    boundary     = hs_fall & (vs_pend | vs_fall);
    v_next       = boundary ? '0 : (hs_fall ? sat_inc_pos(v_cnt) : v_cnt);
    vs_pend_next = boundary ? 1'b0 : (vs_fall | vs_pend);

    h_err = (hs_fall & (h_cnt != H_LAST)) | (hs_rise & (h_next != H_SYNC_W));
    // VS must rise exactly on the line start where v_cnt reaches V_SYNC.
    v_err = (boundary & (v_cnt != V_LAST)) |
            (vs_rise != (hs_fall & (v_next == V_SYNC_W)));
    err_now = h_err | v_err;

    act_next  = (h_next >= H_FIRST) && (h_next <= H_END) &&
                (v_next >= V_FIRST) && (v_next <= V_END);
    x_next    = act_next ? (h_next - H_FIRST) : '0;
    y_next    = act_next ? (v_next - V_FIRST) : '0;
    green_hit = i_pix_stb & act_next & (i_g != 3'd0);
  end

  // Lock FSM: errors on the strobe that enters ACQUIRE belong to the
  // previous (unqualified) frame and are not held against the new one.
  always_comb begin
    state_next    = state;
    err_seen_next = err_seen | err_now;
    frame_inc     = 1'b0;
    err_inc       = 1'b0;
    case (state)
      SEARCH: begin
        if (boundary) begin
          state_next    = ACQUIRE;
          err_seen_next = 1'b0;
        end
      end
      ACQUIRE: begin
        if (boundary) begin
          state_next    = (err_seen | err_now) ? ACQUIRE : LOCKED;
          err_seen_next = 1'b0;
        end
      end
      LOCKED: begin
        if (err_now) begin
          state_next = SEARCH;
          err_inc    = 1'b1;
        end else if (boundary) begin
          frame_inc = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      vs_pend      <= 1'b0;
      err_seen     <= 1'b0;
      green_cnt    <= '0;
      o_x          <= '0;
      o_y          <= '0;
      o_active     <= 1'b0;
      o_locked     <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_err_cnt    <= '0;
      o_green_px   <= '0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_pix_stb) begin
        h_cnt        <= h_next;
        v_cnt        <= v_next;
        vs_pend      <= vs_pend_next;
        err_seen     <= err_seen_next;
        o_x          <= x_next;
        o_y          <= y_next;
        o_active     <= act_next;
        o_locked     <= (state_next == LOCKED);
        o_frame_done <= boundary;
        if (frame_inc) o_frame_cnt <= o_frame_cnt + 16'd1;
        if (err_inc)   o_err_cnt   <= sat_inc_err(o_err_cnt);
        // A hit on the boundary strobe belongs to the new frame.
        if (boundary) begin
          o_green_px <= green_cnt;
          green_cnt  <= green_hit ? CNT_W'(1) : '0;
        end else if (green_hit) begin
          green_cnt  <= green_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor using a shrunken video mode so whole frames,
// relocks and error saturation fit in a short run.
// Mode: line = 2 sync + 1 bp + 4 active + 1 fp = 8 samples,
//       frame = 2 sync + 1 bp + 3 active + 1 fp = 7 lines.
module tb_vga_sync_monitor;

  localparam int TH_ACTIVE = 4, TH_FP = 1, TH_SYNC = 2, TH_BP = 1;
  localparam int TV_ACTIVE = 3, TV_FP = 1, TV_SYNC = 2, TV_BP = 1;
  localparam int TH_TOTAL  = 8;
  localparam int TV_TOTAL  = 7;

  logic        clk = 1'b0;
  logic        rst, stb, hs, vs;
  logic [1:0]  r;
  logic [2:0]  g, b;
  logic [9:0]  o_x, o_y;
  logic        o_active, o_locked, o_frame_done;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_err_cnt;
  logic [18:0] o_green_px;

  vga_sync_monitor #(
    .H_ACTIVE(TH_ACTIVE), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_ACTIVE(TV_ACTIVE), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pix_stb   (stb),
    .i_hs        (hs),
    .i_vs        (vs),
    .i_r         (r),
    .i_g         (g),
    .i_b         (b),
    .o_x         (o_x),
    .o_y         (o_y),
    .o_active    (o_active),
    .o_locked    (o_locked),
    .o_frame_done(o_frame_done),
    .o_frame_cnt (o_frame_cnt),
    .o_err_cnt   (o_err_cnt),
    .o_green_px  (o_green_px)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int h;
    int gval;
    int act;
    int x;
    int y;
  } probe_t;

  probe_t probes[7];

  int n_cmp = 0;
  int n_bad = 0;
  int gh = 0, gv = 0;
  int hlen = TH_TOTAL, vtot = TV_TOTAL, idle = 3;
  int s_x, s_y, s_act, s_lock, s_fd, s_fd2, s_fcnt, s_err, s_green;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    s_x     = int'(o_x);
    s_y     = int'(o_y);
    s_act   = int'(o_active);
    s_lock  = int'(o_locked);
    s_fd    = int'(o_frame_done);
    s_fcnt  = int'(o_frame_cnt);
    s_err   = int'(o_err_cnt);
    s_green = int'(o_green_px);
  endtask

  // One strobed sample; outputs are captured on the falling edge after the
  // capturing rising edge, and o_frame_done again one cycle later.
  task automatic pix(input logic hs_v, input logic vs_v, input logic [2:0] g_v);
    hs  = hs_v;
    vs  = vs_v;
    g   = g_v;
    r   = 2'd1;
    b   = 3'd2;
    stb = 1'b1;
    @(negedge clk);
    snap();
    stb   = 1'b0;
    s_fd2 = 0;
    if (idle > 0) begin
      @(negedge clk);
      s_fd2 = int'(o_frame_done);
      repeat (idle - 1) @(negedge clk);
    end
  endtask

  // Emit the sample at the generator position and advance it.
  task automatic step(input logic [2:0] g_v);
    logic hs_v, vs_v;
    hs_v = (gh < TH_SYNC) ? 1'b0 : 1'b1;
    vs_v = (gv < TV_SYNC) ? 1'b0 : 1'b1;
    pix(hs_v, vs_v, g_v);
    gh++;
    if (gh >= hlen) begin
      gh = 0;
      gv++;
      if (gv >= vtot) gv = 0;
    end
  endtask

  // mode 0: no green; 1: 2x2 square inside active plus green on the
  // front-porch column (must not count); 2: green everywhere.
  function automatic logic [2:0] green_at(input int mode, input int h, input int v);
    if (mode == 1) begin
      if ((h >= 4 && h <= 5 && v >= 4 && v <= 5) || h == 7) return 3'd5;
      return 3'd0;
    end
    if (mode == 2) return 3'd1;
    return 3'd0;
  endfunction

  task automatic run_frame(input int mode);
    do step(green_at(mode, gh, gv)); while (!(gh == 0 && gv == 0));
  endtask

  task automatic end_line();
    do step(3'd0); while (gh != 0);
  endtask

  task automatic bad_line();
    end_line();
    hlen = TH_TOTAL + 1;
    end_line();
    hlen = TH_TOTAL;
  endtask

  task automatic boundary(input string tag, input int lck, input int fc,
                          input int ec, input int gp);
    step(3'd0);
    chk({tag, " frame_done"}, s_fd, 1);
    chk({tag, " locked"}, s_lock, lck);
    chk({tag, " frame_cnt"}, s_fcnt, fc);
    chk({tag, " err_cnt"}, s_err, ec);
    chk({tag, " green_px"}, s_green, gp);
  endtask

  task automatic chk_zero(input string tag);
    snap();
    chk({tag, " x"}, s_x, 0);
    chk({tag, " y"}, s_y, 0);
    chk({tag, " active"}, s_act, 0);
    chk({tag, " locked"}, s_lock, 0);
    chk({tag, " frame_done"}, s_fd, 0);
    chk({tag, " frame_cnt"}, s_fcnt, 0);
    chk({tag, " err_cnt"}, s_err, 0);
    chk({tag, " green_px"}, s_green, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    probes[0] = '{v: 3, h: 2, gval: 1, act: 0, x: 0, y: 0};
    probes[1] = '{v: 3, h: 3, gval: 1, act: 1, x: 0, y: 0};
    probes[2] = '{v: 3, h: 6, gval: 0, act: 1, x: 3, y: 0};
    probes[3] = '{v: 3, h: 7, gval: 1, act: 0, x: 0, y: 0};
    probes[4] = '{v: 4, h: 4, gval: 0, act: 1, x: 1, y: 1};
    probes[5] = '{v: 5, h: 6, gval: 1, act: 1, x: 3, y: 2};
    probes[6] = '{v: 6, h: 3, gval: 1, act: 0, x: 0, y: 0};

    rst = 1'b1; stb = 1'b0; hs = 1'b1; vs = 1'b1;
    r = 2'd0; g = 3'd0; b = 3'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Ideal stream: lock at the 2nd boundary, first locked frame at the 3rd.
    boundary("b1", 0, 0, 0, 0);
    chk("b1 frame_done clears", s_fd2, 0);
    run_frame(1);
    chk("acquire frame no lock", s_lock, 0);
    boundary("b2", 1, 0, 0, 4);
    run_frame(2);
    boundary("b3", 1, 1, 0, 12);

    // Coordinate probes across the edges of the active area.
    for (int i = 0; i < 7; i++) begin
      int guard;
      guard = 0;
      while (!(gv == probes[i].v && gh == probes[i].h) && guard < 200) begin
        step(3'd0);
        guard++;
      end
      chk($sformatf("probe%0d reach", i), guard < 200 ? 1 : 0, 1);
      step(3'(probes[i].gval));
      chk($sformatf("probe%0d active", i), s_act, probes[i].act);
      chk($sformatf("probe%0d x", i), s_x, probes[i].x);
      chk($sformatf("probe%0d y", i), s_y, probes[i].y);
    end
    run_frame(0);
    boundary("b4", 1, 2, 0, 2);

    // One line of 9 samples while locked.
    bad_line();
    chk("before hs err locked", s_lock, 1);
    step(3'd0);
    chk("hs err locked", s_lock, 0);
    chk("hs err err_cnt", s_err, 1);
    chk("hs err no frame_done", s_fd, 0);
    run_frame(0);
    boundary("b5", 0, 2, 1, 0);
    run_frame(0);
    boundary("b6", 1, 2, 1, 0);
    run_frame(0);
    boundary("b7", 1, 3, 1, 0);

    // Short frame while locked: v error coincides with the boundary.
    vtot = TV_TOTAL - 1;
    run_frame(0);
    vtot = TV_TOTAL;
    boundary("b8", 0, 3, 2, 0);
    chk("b8 frame_done clears", s_fd2, 0);

    // Error inside ACQUIRE restarts acquisition.
    run_frame(2);
    boundary("b9", 0, 3, 2, 12);
    bad_line();
    run_frame(0);
    boundary("b10", 0, 3, 2, 0);
    run_frame(1);
    boundary("b11", 1, 3, 2, 4);

    // Reset mid-frame while locked, then relock from mid-frame.
    while (!(gv == 4 && gh == 4)) step(3'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midreset");
    run_frame(0);
    boundary("b12", 0, 0, 0, 0);
    run_frame(0);
    boundary("b13", 1, 0, 0, 0);

    // 300 lock/error cycles, strobe every clock.
    idle = 0;
    for (int i = 0; i < 300; i++) begin
      bad_line();
      step(3'd0);
      if (i == 0 || i == 253 || i == 254 || i == 299)
        chk($sformatf("sat err_cnt after %0d", i + 1), s_err, (i + 1 > 255) ? 255 : i + 1);
      run_frame(0);
      step(3'd0);
      run_frame(0);
      step(3'd0);
    end
    chk("sat final locked", s_lock, 1);
    chk("sat final frame_cnt", s_fcnt, 0);
    chk("sat final err_cnt", s_err, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
